key_event: RTL
==============

# key_event

Converts a debounced push-button level into single-cycle event pulses for the game controller: press, release, long-press and typematic auto-repeat. It sits directly downstream of the per-button debouncer. It consumes the debouncer's clean `O` level and hands `clk`-synchronous strobes to the menu and movement FSMs, so no consumer performs its own edge detection or hold timing.

## Interface
- `LONG_CYC`, default 50_000_000: cycles a key must stay down after the press edge before `long_press` fires (0.5 s at 100 MHz); legal range ≥ 2.
- `REP_CYC`, default 10_000_000: cycles between successive `repeat` pulses; legal range ≥ 1.
- `REP_EN`, default 1: 1 enables auto-repeat after long-press; 0 suppresses all `repeat` pulses.
- `CW`, default 26: counter width; must satisfy 2^CW > max(`LONG_CYC`, `REP_CYC`).
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `I` input 1: debounced key level, 1 = pressed; already synchronous to `clk`.
- `press` output 1: one-cycle strobe on the press edge.
- `release` output 1: one-cycle strobe on the release edge.
- `long_press` output 1: one-cycle strobe when the hold time reaches `LONG_CYC`.
- `repeat` output 1: one-cycle strobe every `REP_CYC` cycles after `long_press`.
- `held` output 1: level, 1 while the key is tracked as down (state ≠ IDLE).

## Operation
- Internal previous-sample register `i_q`, plus a `CW`-bit counter `cnt`.
- FSM has three states: IDLE, DOWN, RPT.
  - IDLE → DOWN when `I`=1 and `i_q`=0: `press`<=1, `cnt`<=1.
  - DOWN, `I`=1, `cnt`<`LONG_CYC`: `cnt`<=`cnt`+1.
  - DOWN, `I`=1, `cnt`==`LONG_CYC`: `long_press`<=1, `cnt`<=1, go to RPT.
  - RPT, `I`=1, `cnt`<`REP_CYC`: `cnt`<=`cnt`+1.
  - RPT, `I`=1, `cnt`==`REP_CYC`: `repeat`<=`REP_EN`, `cnt`<=1. Remain in RPT indefinitely; the counter wraps only through this reload and never overflows.
  - DOWN or RPT, `I`=0: `release`<=1, `cnt`<=0, go to IDLE.
- All outputs are registered. Strobes default to 0 every cycle unless set as above.
- Simultaneous events: if `I` drops on the edge where `long_press` or `repeat` would fire, only `release` is asserted.
- Every press produces exactly one `release`. At most one `long_press` fires per press.
- `held` = 1 in DOWN and RPT. It rises on the same edge as `press` and falls on the same edge as `release`.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets: state IDLE, `cnt`=0, `i_q`=1, and all of `press`, `release`, `long_press`, `repeat`, `held` = 0.
- Because `i_q` resets to 1, a key held through reset produces no events until it is released and pressed again. Its release in IDLE is silent.
- Reset asserted mid-hold aborts immediately with no `release` strobe.
- Latency: `I` sampled 1 at edge N (with `i_q`=0) → `press` high for the cycle following edge N.
- `long_press` is registered at edge N+`LONG_CYC`.
- `repeat` pulses are registered at edges N+`LONG_CYC`+k·`REP_CYC`, k ≥ 1.
- `I` first sampled 0 at edge M → `release` high for the cycle following edge M.
- A one-cycle press (`I` high for a single sample) gives `press` at edge N and `release` at edge N+1.
- Back-to-back press is legal: `I`=1 at edge M+1 right after a release yields `press` at edge M+1.

## Test plan
- Reset with `I`=0, then a single press (`LONG_CYC`=8, `REP_CYC`=3): `I` high at edge 10 and held 5 cycles → `press` at edge 10, `release` at edge 15, `held` high over edges 10–14, and no `long_press`.
- Long hold with `REP_EN`=1: `I` high from edge 10 to edge 30 → `long_press` at edge 18, `repeat` at edges 21, 24, 27, 30? No: `I` falls at edge 30, so `release` at 30 and `repeat` at 21, 24, 27 only.
- `REP_EN`=0 with the same stimulus → `long_press` at edge 18, no `repeat`, `release` at edge 30.
- Collision: `I` released exactly at edge 18 → `release`=1 and `long_press`=0 on that edge.
- Key held across reset: `I`=1 while `rst_n` is deasserted at edge 5 → no strobes. Drop `I` at edge 9 → still no strobes. Re-press at edge 12 → `press` at edge 12.
- Reset mid-hold: press at edge 10, `rst_n`=0 at edge 14 → all outputs 0 from edge 14, with no `release` pulse.

Source files
------------

// File: rtl/key_event.sv
// key_event: turns a debounced key level into press/release/long-press/auto-repeat strobes.
module key_event #(
    parameter int LONG_CYC = 50_000_000,
    parameter int REP_CYC  = 10_000_000,
    parameter bit REP_EN   = 1'b1,
    parameter int CW       = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic I,
    output logic press,
    output logic key_release,
    output logic long_press,
    output logic key_repeat,
    output logic held
);
    typedef enum logic [1:0] {IDLE, DOWN, RPT} state_t;
    state_t        state;
    logic          i_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            i_q         <= 1'b1;
            press       <= 1'b0;
            key_release <= 1'b0;
            long_press  <= 1'b0;
            key_repeat  <= 1'b0;
            held        <= 1'b0;
        end else begin
            i_q         <= I;
            press       <= 1'b0;
            key_release <= 1'b0;
            long_press  <= 1'b0;
            key_repeat  <= 1'b0;
            case (state)
                IDLE: if (I && !i_q) begin
                    state <= DOWN;
                    press <= 1'b1;
                    held  <= 1'b1;
                    cnt   <= CW'(1);
                end
                DOWN, RPT: if (!I) begin
                    // release wins over a long-press/repeat due on the same edge
                    state       <= IDLE;
                    key_release <= 1'b1;
                    held        <= 1'b0;
                    cnt         <= '0;
                end else if (state == DOWN && cnt == CW'(LONG_CYC)) begin
                    state      <= RPT;
                    long_press <= 1'b1;
                    cnt        <= CW'(1);
                end else if (state == RPT && cnt == CW'(REP_CYC)) begin
                    key_repeat <= REP_EN;
                    cnt        <= CW'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
